time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter CLK_HZ, default 100000000, clk cycles per second; legal range 4 or more.
REQ-002 Port clk, input, 1, 100 MHz system clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1, asynchronous active-high reset (HA asynchronous reset).
REQ-004 Port run, input, 1, level; 1 = timekeeping advances, 0 = time frozen.
REQ-005 Port set_min, input, 1, single-cycle pulse that advances minutes by one.
REQ-006 Port set_hr, input, 1, single-cycle pulse that advances hours by one.
REQ-007 Port time_bcd, output, 16, time as {hr_tens, hr_ones, min_tens, min_ones}, 4-bit BCD digits; feeds the seven-segment display data input.
REQ-008 Port sec_bcd, output, 8, seconds as {sec_tens, sec_ones} BCD.
REQ-009 Port sec_tick, output, 1, one-cycle pulse on each seconds advance.
REQ-010 Port colon, output, 1, 1 during the first half of each second; used for the blink indicator.

Function
REQ-011 Prescaler: counter 0..CLK_HZ-1, width ceil(log2(CLK_HZ)).
- Increments each cycle while run=1; holds while run=0.
REQ-012 Prescaler rollover: in the cycle the prescaler equals CLK_HZ-1 with run=1, the prescaler returns to 0 and a second event occurs.
REQ-013 Second event: next edge registers sec_tick=1 for exactly one cycle and seconds advance; sec_tick is 0 in all other cycles.
REQ-014 Seconds count 00..59 BCD.
- Ones 9 -> 0 with a tens carry.
- 59 -> 00 carries one minute in the same edge.
REQ-015 Minutes count 00..59 BCD; 59 -> 00 carries one hour in the same edge.
REQ-016 Hours count 00..23 BCD.
- 09 -> 10 and 19 -> 20.
- 23 -> 00 with no further carry.
REQ-017 Full chain 23:59:59 -> 00:00:00 completes in a single edge; no intermediate values are visible on outputs.
REQ-018 All outputs are registered; time_bcd and sec_bcd change on the edge after the triggering cycle (latency 1).
REQ-019 set_min=1: minutes advance mod 60 with no carry into hours; seconds clear to 00; prescaler clears to 0.
REQ-020 set_hr=1: hours advance mod 24; minutes unchanged; seconds clear to 00; prescaler clears to 0.
REQ-021 set_min and set_hr in the same cycle: both apply independently; seconds and prescaler clear.
REQ-022 A set pulse coincident with a prescaler rollover:
- set has priority;
- the second event is suppressed, with no sec_tick and no seconds/minute carry.
REQ-023 Set pulses act regardless of run.
REQ-024 A set pulse held high for N cycles produces N increments; debounce and edge detection are upstream.
REQ-025 colon is registered; it is 1 when the prescaler is below CLK_HZ/2 (integer division), else 0.
- Frozen while run=0.
REQ-026 Digit values above 9, or hour/minute values outside range, are unreachable from reset.
- No recovery logic is required beyond reset.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 rst=1 asynchronously forces, regardless of clk:
- prescaler=0, time_bcd=16'h0000, sec_bcd=8'h00;
- sec_tick=0, colon=0.
REQ-029 While rst=1, all inputs are ignored.
- The first prescaler increment occurs on the first rising edge with rst=0 and run=1.
- colon becomes 1 after that edge.
REQ-030 Reset asserted mid-second or mid-carry discards partial state; no tick is issued on release.

Verification (bench runs with CLK_HZ=10)
REQ-031 Scenario: rst pulse, then run=0 for 50 cycles -> time_bcd=0000, sec_bcd=00, sec_tick never 1, colon=0.
REQ-032 Scenario: run=1 from reset for 10 cycles -> exactly one sec_tick, on the edge after the 10th counting cycle; sec_bcd=01.
- colon high for 5 cycles and low for 5 cycles per second.
REQ-033 Scenario: 23 set_hr pulses, 59 set_min pulses, then run for 600 cycles -> time 23:59:00 -> 23:59:59 -> time_bcd=0000, sec_bcd=00 on the 60th tick, in a single edge.
REQ-034 Scenario: minutes=59, hours=05, single set_min -> time_bcd=0500 with hours unchanged; from hours=23, single set_hr -> 00xx with minutes unchanged.
REQ-035 Scenario: set_min asserted in the prescaler=9 cycle with seconds=59 and minutes=10 -> minutes=11, seconds=00, no sec_tick, prescaler restarts from 0.
REQ-036 Scenario: rst asserted asynchronously between edges at 12:34:56 -> outputs read 0000/00 before the next edge; counting resumes from 00:00:00 after release.

Source files
------------

// File: rtl/time_keeper.sv
// Time-of-day keeper: prescaled seconds, BCD HH:MM:SS with set pulses.
// All outputs come straight from registers; set pulses take priority over the second event.
module time_keeper #(
  parameter int CLK_HZ = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        set_min,
  input  logic        set_hr,
  output logic [15:0] time_bcd,
  output logic [7:0]  sec_bcd,
  output logic        sec_tick,
  output logic        colon
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    hr_q, hr_d;
  logic          tick_q, tick_d;
  logic          colon_q, colon_d;
  logic          anySet, secEvent, minCarry, hrCarry;

  // Two-digit BCD increment that wraps to 00 after maxV.
  function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] maxV);
    if (v == maxV) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    anySet   = set_min | set_hr;
    secEvent = run && (presc_q == PRESC_MAX) && !anySet;
    minCarry = secEvent && (sec_q == 8'h59);
    hrCarry  = minCarry && (min_q == 8'h59);

    presc_d = presc_q;
    if (anySet) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = secEvent ? '0 : presc_q + PW'(1);
    end

    sec_d = sec_q;
    if (anySet) begin
      sec_d = 8'h00;
    end else if (secEvent) begin
      sec_d = bcdInc(sec_q, 8'h59);
    end

    min_d = min_q;
    if (set_min || minCarry) begin
      min_d = bcdInc(min_q, 8'h59);
    end

    hr_d = hr_q;
    if (set_hr || hrCarry) begin
      hr_d = bcdInc(hr_q, 8'h23);
    end

    tick_d = secEvent;
    // Colon tracks the prescaler value that will be visible after this edge.
    colon_d = run ? (presc_d < PRESC_HALF) : colon_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      hr_q    <= 8'h00;
      tick_q  <= 1'b0;
      colon_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      tick_q  <= tick_d;
      colon_q <= colon_d;
    end
  end

  assign time_bcd = {hr_q, min_q};
  assign sec_bcd  = sec_q;
  assign sec_tick = tick_q;
  assign colon    = colon_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper at CLK_HZ=10 (one second = 10 clocks).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_time_keeper;

  logic        clk;
  logic        rst;
  logic        run;
  logic        setMin;
  logic        setHr;
  logic [15:0] timeBcd;
  logic [7:0]  secBcd;
  logic        secTick;
  logic        colon;

  int checks;
  int errors;
  int tickCount;
  int colonCount;

  time_keeper #(.CLK_HZ(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .set_min  (setMin),
    .set_hr   (setHr),
    .time_bcd (timeBcd),
    .sec_bcd  (secBcd),
    .sec_tick (secTick),
    .colon    (colon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then land 1 unit past the next rising edge.
  task automatic applyStimulus(input logic r, input logic rn, input logic sm, input logic sh);
    rst    = r;
    run    = rn;
    setMin = sm;
    setHr  = sh;
    @(posedge clk);
    #1;
    tickCount  += int'(secTick);
    colonCount += int'(colon);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; run = 1'b0; setMin = 1'b0; setHr = 1'b0;
    #1;
    checkOutput("reset_time", 32'(timeBcd), 32'h0000);
    checkOutput("reset_sec", 32'(secBcd), 32'h00);
    checkOutput("reset_tick", 32'(secTick), 32'd0);
    checkOutput("reset_colon", 32'(colon), 32'd0);
    @(posedge clk);
    #1;

    // Frozen time with run low.
    tickCount = 0; colonCount = 0;
    repeat (50) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("frozen_time", 32'(timeBcd), 32'h0000);
    checkOutput("frozen_sec", 32'(secBcd), 32'h00);
    checkOutput("frozen_ticks", 32'(tickCount), 32'd0);
    checkOutput("frozen_colon", 32'(colonCount), 32'd0);

    // First second from reset.
    tickCount = 0; colonCount = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("first_colon", 32'(colon), 32'd1);
    repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("no_tick_before_10", 32'(tickCount), 32'd0);
    checkOutput("sec_before_10", 32'(secBcd), 32'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("tick_at_10", 32'(secTick), 32'd1);
    checkOutput("sec_after_10", 32'(secBcd), 32'h01);
    checkOutput("colon_high_count", 32'(colonCount), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("tick_one_cycle", 32'(secTick), 32'd0);

    // Preset 23:59 with held set pulses (run low), then roll over midnight.
    repeat (23) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("set_hr_23", 32'(timeBcd), 32'h2300);
    checkOutput("set_clears_sec", 32'(secBcd), 32'h00);
    repeat (59) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("set_min_59", 32'(timeBcd), 32'h2359);
    tickCount = 0;
    repeat (599) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_midnight_time", 32'(timeBcd), 32'h2359);
    checkOutput("pre_midnight_sec", 32'(secBcd), 32'h59);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("midnight_time", 32'(timeBcd), 32'h0000);
    checkOutput("midnight_sec", 32'(secBcd), 32'h00);
    checkOutput("midnight_tick", 32'(secTick), 32'd1);
    checkOutput("midnight_tick_count", 32'(tickCount), 32'd60);

    // Set wrap without carry.
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (59) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("preset_0559", 32'(timeBcd), 32'h0559);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("min_wrap_no_carry", 32'(timeBcd), 32'h0500);
    repeat (18) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("preset_2307", 32'(timeBcd), 32'h2307);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hr_wrap", 32'(timeBcd), 32'h0007);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("both_sets", 32'(timeBcd), 32'h0108);

    // Set pulse coincident with rollover at 01:10:59.
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (599) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_collide_time", 32'(timeBcd), 32'h0110);
    checkOutput("pre_collide_sec", 32'(secBcd), 32'h59);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("collide_time", 32'(timeBcd), 32'h0111);
    checkOutput("collide_sec", 32'(secBcd), 32'h00);
    checkOutput("collide_no_tick", 32'(secTick), 32'd0);
    tickCount = 0;
    repeat (9) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("restart_no_early_tick", 32'(tickCount), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("restart_tick", 32'(secTick), 32'd1);
    checkOutput("restart_sec", 32'(secBcd), 32'h01);

    // Asynchronous reset at 12:34:56.
    repeat (11) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (23) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (560) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("preset_1234", 32'(timeBcd), 32'h1234);
    checkOutput("preset_56", 32'(secBcd), 32'h56);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_time", 32'(timeBcd), 32'h0000);
    checkOutput("async_rst_sec", 32'(secBcd), 32'h00);
    @(posedge clk);
    #1;
    tickCount = 0;
    repeat (9) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_no_tick", 32'(tickCount), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_tick", 32'(secTick), 32'd1);
    checkOutput("post_rst_time", 32'(timeBcd), 32'h0000);
    checkOutput("post_rst_sec", 32'(secBcd), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
